plot_queue: RTL and testbench
=============================

Name: plot_queue

Overview:
- Receiving end of the pixel-processing plot stream. It accepts the one-cycle (x, y) write strobes produced by the colour-process FSM pool and buffers them in a FIFO.
- It drains the FIFO to the framebuffer plot port at a fixed, paced rate, so that bursts of detected pixels are not lost when the downstream writer is slower or paused.
- It sits between the pixel-processing block and the VGA adapter's x/y/plot inputs.

Parameters:
DEPTH, 16, FIFO entries; must be a power of 2, at least 2
AW, 4, log2(DEPTH)
XW, 9, x coordinate width
YW, 8, y coordinate width
DRAIN_DIV, 2, minimum clock cycles between successive vga_plot pulses; at least 1

Ports:
clock50  in  1  system clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  plot request strobe, sampled every cycle
in_x  in  XW  request x
in_y  in  YW  request y
in_ready  out  1  high when the FIFO is not full (count != DEPTH)
enable  in  1  drain enable; low pauses output and the queue keeps filling
flush  in  1  synchronous clear of the queue contents
vga_x  out  XW  framebuffer write x
vga_y  out  YW  framebuffer write y
vga_plot  out  1  one-cycle framebuffer write strobe
count  out  AW+1  current occupancy, 0..DEPTH
drop_count  out  16  saturating count of requests lost to a full queue
overflow  out  1  sticky; set on the first drop

Behaviour:
- Reset (asynchronous, while reset=1):
  - All registers clear: pointers=0, count=0, pace_cnt=0, last_valid=0.
  - vga_x=0, vga_y=0, vga_plot=0, drop_count=0, overflow=0.
  - in_ready=1, because it is a combinational decode of count.
- Storage: circular buffer with wr_ptr/rd_ptr (AW bits, wrap modulo DEPTH) and a separate count register.
- Push decision, evaluated on the pre-edge registered state:
  - Filtered: in_valid=1, last_valid=1 and (in_x,in_y) equals last_xy. The request is discarded silently; no drop is counted.
  - Accepted: in_valid=1, not filtered, count<DEPTH. The entry is written at wr_ptr, wr_ptr increments, last_xy is updated and last_valid is set.
  - Dropped: in_valid=1, not filtered, count==DEPTH. drop_count increments, saturating at 16'hFFFF, and overflow is set.
  - A pop in the same cycle does NOT free space for the push; there is no bypass.
- Pacing counter pace_cnt (width ceil(log2(DRAIN_DIV))+1):
  - Reloads DRAIN_DIV-1 on a pop.
  - Otherwise decrements while nonzero.
- Pop condition: enable=1, count>0, pace_cnt==0, flush=0.
  - On a pop, vga_x/vga_y register the entry at rd_ptr, vga_plot=1 for exactly the following cycle, and rd_ptr increments.
  - When no pop occurs, vga_plot=0 and vga_x/vga_y hold their last values.
- Occupancy: count_next = count + push - pop. A simultaneous push and pop with 0<count<DEPTH leaves count unchanged.
- Latency: a request accepted at edge E into an empty queue with pace_cnt=0 and enable=1 produces vga_plot=1 in the cycle following edge E+1, i.e. 2 cycles.
- Throughput: at most one vga_plot every DRAIN_DIV cycles. With DRAIN_DIV=1, back-to-back pulses are allowed.
- Duplicate filter state:
  - last_xy/last_valid track the last accepted coordinate, independent of the queue draining.
  - last_valid is cleared only by reset or flush.
- Flush:
  - Clears pointers, count, pace_cnt and last_valid; vga_plot=0 next cycle.
  - It has priority over push and pop in the same cycle. A concurrent push is discarded and not counted as a drop.
  - drop_count and overflow are NOT cleared by flush.
- enable low: no pops occur, and pace_cnt keeps counting down to 0. When enable rises, the first pop can occur on that same cycle if count>0.
- Reset mid-drain: any pulse in flight is aborted immediately (vga_plot forced to 0 asynchronously) and all queued entries are lost.

Test Plan:
1. Basic path: reset, then enable=1, DRAIN_DIV=2, a single in_valid with (10,20). Required: vga_plot high exactly once, 2 cycles after acceptance, with vga_x=10, vga_y=20; count returns to 0.
2. Burst and pacing: enable=1, 8 consecutive distinct requests (x=0..7, y=5). Required: 8 vga_plot pulses spaced exactly 2 cycles apart, in order x=0..7; drop_count=0.
3. Overflow: enable=0, 20 distinct requests. Required: count=16, in_ready=0, drop_count=4, overflow=1. Then enable=1: exactly the first 16 coordinates are emitted in order.
4. Duplicate filter: requests (3,3), (3,3), (4,4), (3,3). Required: 3 entries stored and emitted as (3,3), (4,4), (3,3); drop_count=0.
5. Flush with a concurrent push: fill 5 entries with enable=0, then assert flush and in_valid (9,9) in the same cycle. Required: count=0 next cycle, no vga_plot afterwards, drop_count unchanged. A subsequent (3,3) previously seen is accepted, because last_valid was cleared.
6. Async reset mid-drain: assert reset between pulses of scenario 2 with no clock edge. Required: vga_plot=0, count=0, drop_count=0, overflow=0 immediately, and the outputs stay quiet after release.

Source files
------------

// File: rtl/plot_queue_if.sv
// Plot-stream bundle between the pixel-processing pool, the plot queue and the
// framebuffer plot port. The slave modport is the queue's view of it.
interface plot_queue_if #(
  parameter int XW = 9,
  parameter int YW = 8,
  parameter int AW = 4
);
  logic          in_valid;
  logic [XW-1:0] in_x;
  logic [YW-1:0] in_y;
  logic          in_ready;
  logic          enable;
  logic          flush;
  logic [XW-1:0] vga_x;
  logic [YW-1:0] vga_y;
  logic          vga_plot;
  logic [AW:0]   count;
  logic [15:0]   drop_count;
  logic          overflow;

  modport slave (
    input  in_valid, in_x, in_y, enable, flush,
    output in_ready, vga_x, vga_y, vga_plot, count, drop_count, overflow
  );

  modport master (
    output in_valid, in_x, in_y, enable, flush,
    input  in_ready, vga_x, vga_y, vga_plot, count, drop_count, overflow
  );
endinterface

// File: rtl/plot_queue.sv
// Paced plot FIFO: buffers (x,y) write strobes, drops consecutive duplicates,
// and drains to the framebuffer plot port at most once every DRAIN_DIV cycles.
module plot_queue #(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int XW        = 9,
  parameter int YW        = 8,
  parameter int DRAIN_DIV = 2
) (
  input  logic         clock50,
  input  logic         reset,
  plot_queue_if.slave  bus
);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(DRAIN_DIV) + 1;
  localparam int EW = XW + YW;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_pace_cnt;
  logic [EW-1:0] r_last_xy;
  logic          r_last_valid;
  logic [XW-1:0] r_vga_x;
  logic [YW-1:0] r_vga_y;
  logic          r_vga_plot;
  logic [15:0]   r_drop_count;
  logic          r_overflow;

  logic [EW-1:0] w_in_xy;
  logic          w_full, w_filt, w_push, w_drop, w_pop;

  // Decisions use only pre-edge state, so a same-cycle pop never frees room for a push.
  always_comb begin
    w_in_xy = {bus.in_x, bus.in_y};
    w_full  = (r_count == CW'(DEPTH));
    w_filt  = bus.in_valid && r_last_valid && (w_in_xy == r_last_xy);
    w_push  = bus.in_valid && !w_filt && !w_full && !bus.flush;
    w_drop  = bus.in_valid && !w_filt &&  w_full && !bus.flush;
    w_pop   = bus.enable && (r_count != '0) && (r_pace_cnt == '0) && !bus.flush;
  end

  // Storage array carries data only, so it is left out of reset.
  always_ff @(posedge clock50) begin
    if (w_push) r_mem[r_wr_ptr] <= w_in_xy;
  end

  always_ff @(posedge clock50 or posedge reset) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_pace_cnt   <= '0;
      r_last_xy    <= '0;
      r_last_valid <= 1'b0;
      r_vga_x      <= '0;
      r_vga_y      <= '0;
      r_vga_plot   <= 1'b0;
      r_drop_count <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_vga_plot <= w_pop;
      if (w_drop) begin
        r_drop_count <= sat_inc(r_drop_count);
        r_overflow   <= 1'b1;
      end
      if (bus.flush) begin
        r_wr_ptr     <= '0;
        r_rd_ptr     <= '0;
        r_count      <= '0;
        r_pace_cnt   <= '0;
        r_last_valid <= 1'b0;
      end else begin
        if (w_push) begin
          r_wr_ptr     <= r_wr_ptr + AW'(1);
          r_last_xy    <= w_in_xy;
          r_last_valid <= 1'b1;
        end
        if (w_pop) begin
          r_rd_ptr   <= r_rd_ptr + AW'(1);
          {r_vga_x, r_vga_y} <= r_mem[r_rd_ptr];
          r_pace_cnt <= PW'(DRAIN_DIV - 1);
        end else if (r_pace_cnt != '0) begin
          r_pace_cnt <= r_pace_cnt - PW'(1);
        end
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  assign bus.in_ready   = !w_full;
  assign bus.vga_x      = r_vga_x;
  assign bus.vga_y      = r_vga_y;
  assign bus.vga_plot   = r_vga_plot;
  assign bus.count      = r_count;
  assign bus.drop_count = r_drop_count;
  assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_plot_queue.sv
// Directed bench for plot_queue: expected plots go into a scoreboard queue and a
// negedge monitor checks every vga_plot pulse against it.
module tb_plot_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   acc_cyc = 0;
  logic [16:0] exp_q [$];
  int   pulse_t [$];

  plot_queue_if #(.XW(9), .YW(8), .AW(4)) bus ();

  plot_queue #(.DEPTH(16), .AW(4), .XW(9), .YW(8), .DRAIN_DIV(2)) dut (
    .clock50 (clk),
    .reset   (rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.vga_plot === 1'b1) begin
      logic [16:0] e;
      pulse_t.push_back(cyc);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_plot got=(%0d,%0d) want=none", bus.vga_x, bus.vga_y);
      end else begin
        e = exp_q.pop_front();
        if ({bus.vga_x, bus.vga_y} !== e) begin
          bad++;
          $display("FAIL plot_xy got=(%0d,%0d) want=(%0d,%0d)",
                   bus.vga_x, bus.vga_y, e[16:8], e[7:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic push(input int x, input int y, input bit expect_out);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_x     = 9'(x);
    bus.in_y     = 8'(y);
    acc_cyc      = cyc + 1;
    if (expect_out) exp_q.push_back({9'(x), 8'(y)});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      idle(1);
      n++;
    end
    idle(3);
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    int lat;
    bit found;
    bus.in_valid = 1'b0;
    bus.in_x     = '0;
    bus.in_y     = '0;
    bus.enable   = 1'b0;
    bus.flush    = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_plot", bus.vga_plot, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_ready", bus.in_ready, 1);
    chk("rst_drop", bus.drop_count, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_x", bus.vga_x, 0);
    rst = 1'b0;

    // 1: single request, 2-cycle latency
    bus.enable = 1'b1;
    pulse_t.delete();
    push(10, 20, 1);
    wait_drain("s1_drain", 20);
    idle(4);
    chk("s1_npulse", pulse_t.size(), 1);
    lat = (pulse_t.size() > 0) ? pulse_t[0] - acc_cyc : -1;
    chk("s1_latency", lat, 1);
    chk("s1_count", bus.count, 0);

    // 2: burst of 8, paced every 2 cycles
    pulse_t.delete();
    for (int i = 0; i < 8; i++) push(i, 5, 1);
    wait_drain("s2_drain", 60);
    chk("s2_npulse", pulse_t.size(), 8);
    for (int i = 1; i < pulse_t.size(); i++) chk("s2_gap", pulse_t[i] - pulse_t[i-1], 2);
    chk("s2_drop", bus.drop_count, 0);

    // 4: duplicate filter
    push(3, 3, 1);
    push(3, 3, 0);
    push(4, 4, 1);
    push(3, 3, 1);
    wait_drain("s4_drain", 40);
    chk("s4_drop", bus.drop_count, 0);
    chk("s4_count", bus.count, 0);

    // 3: overflow with drain paused
    bus.enable = 1'b0;
    for (int i = 0; i < 20; i++) push(100 + i, i, i < 16);
    idle(1);
    chk("s3_count", bus.count, 16);
    chk("s3_ready", bus.in_ready, 0);
    chk("s3_drop", bus.drop_count, 4);
    chk("s3_ovf", bus.overflow, 1);
    bus.enable = 1'b1;
    wait_drain("s3_drain", 100);
    chk("s3_ready2", bus.in_ready, 1);

    // 5: flush with a concurrent push
    bus.enable = 1'b0;
    for (int i = 0; i < 4; i++) push(50 + i, 7, 0);
    push(3, 3, 0);
    idle(1);
    chk("s5_fill", bus.count, 5);
    @(negedge clk);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_x     = 9'd9;
    bus.in_y     = 8'd9;
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("s5_count", bus.count, 0);
    chk("s5_drop", bus.drop_count, 4);
    chk("s5_ovf", bus.overflow, 1);
    pulse_t.delete();
    bus.enable = 1'b1;
    idle(6);
    chk("s5_quiet", pulse_t.size(), 0);
    push(3, 3, 1);
    wait_drain("s5_refill", 20);

    // 6: asynchronous reset in the middle of a paced drain
    pulse_t.delete();
    for (int i = 0; i < 8; i++) push(20 + i, 6, 1);
    bus.in_valid = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(posedge clk);
      #1;
      if (pulse_t.size() >= 2 && bus.vga_plot === 1'b1) found = 1'b1;
    end
    chk("s6_reach", found, 1);
    rst = 1'b1;
    #1;
    chk("s6_plot", bus.vga_plot, 0);
    chk("s6_count", bus.count, 0);
    chk("s6_drop", bus.drop_count, 0);
    chk("s6_ovf", bus.overflow, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulse_t.delete();
    idle(12);
    chk("s6_quiet", pulse_t.size(), 0);
    chk("s6_count2", bus.count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
